// File: rtl/ramsdp_bw.sv
// ============================================================================
// Module   : ramsdp_bw
// Brief    : Single-clock simple dual-port RAM. Port A writes with a per-lane
//            mask, port B reads with 1- or 2-cycle latency and a valid strobe.
//            Same-address collisions resolve read-first or write-first.
//            Define RAMSDP_BW_PARITY_EN to store per-lane even parity
//            (adds pinj_a / perr_b).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module ramsdp_bw #(
    parameter int DW    = 32,
    parameter int AW    = 6,
    parameter int BW    = 8,
    parameter int RDLAT = 1,
    parameter int RDW   = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en_a,
    input  logic                we_a,
    input  logic [DW/BW-1:0]    wmask_a,
    input  logic [AW-1:0]       addr_a,
    input  logic [DW-1:0]       din_a,
`ifdef RAMSDP_BW_PARITY_EN
    input  logic                pinj_a,
    output logic [DW/BW-1:0]    perr_b,
`endif
    input  logic                en_b,
    input  logic [AW-1:0]       addr_b,
    output logic [DW-1:0]       dout_b,
    output logic                valid_b
);

    localparam int c_NL    = DW / BW;
    localparam int c_DEPTH = 2 ** AW;

    logic [DW-1:0] r_mem [c_DEPTH];

    logic          w_wr;
    logic          w_coll;
    logic [DW-1:0] w_rd_word;
    logic [DW-1:0] r_dout;
    logic          r_valid;

    assign w_wr   = en_a & we_a;
    assign w_coll = w_wr & en_b & (addr_a == addr_b);

    // The array has no reset; the write is qualified by rst instead.
    always_ff @(posedge clk) begin
        if (!rst && w_wr) begin
            for (int i = 0; i < c_NL; i++) begin
                if (wmask_a[i]) begin
                    r_mem[addr_a][i*BW +: BW] <= din_a[i*BW +: BW];
                end
            end
        end
    end

    // Write-first mode forwards the masked lanes of din_a on a collision.
    always_comb begin
        w_rd_word = r_mem[addr_b];
        for (int i = 0; i < c_NL; i++) begin
            if ((RDW != 0) && w_coll && wmask_a[i]) begin
                w_rd_word[i*BW +: BW] = din_a[i*BW +: BW];
            end
        end
    end

`ifdef RAMSDP_BW_PARITY_EN
    logic [c_NL-1:0] r_par [c_DEPTH];
    logic [c_NL-1:0] w_din_par;
    logic [c_NL-1:0] w_rd_par;
    logic [c_NL-1:0] w_rd_perr;
    logic [c_NL-1:0] r_perr;

    always_comb begin
        for (int i = 0; i < c_NL; i++) begin
            w_din_par[i] = (^din_a[i*BW +: BW]) ^ pinj_a;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && w_wr) begin
            for (int i = 0; i < c_NL; i++) begin
                if (wmask_a[i]) begin
                    r_par[addr_a][i] <= w_din_par[i];
                end
            end
        end
    end

    always_comb begin
        w_rd_par = r_par[addr_b];
        for (int i = 0; i < c_NL; i++) begin
            if ((RDW != 0) && w_coll && wmask_a[i]) begin
                w_rd_par[i] = w_din_par[i];
            end
        end
        for (int i = 0; i < c_NL; i++) begin
            w_rd_perr[i] = (^w_rd_word[i*BW +: BW]) ^ w_rd_par[i];
        end
    end

    assign perr_b = r_perr;
`endif

    generate
        if (RDLAT == 1) begin : g_lat1
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_valid <= 1'b0;
                    r_dout  <= '0;
                end else begin
                    r_valid <= en_b;
                    if (en_b) begin
                        r_dout <= w_rd_word;
                    end
                end
            end
`ifdef RAMSDP_BW_PARITY_EN
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_perr <= '0;
                end else begin
                    r_perr <= en_b ? w_rd_perr : '0;
                end
            end
`endif
        end else begin : g_lat2
            logic          r_s1_valid;
            logic [DW-1:0] r_s1_data;

            // Stage 1 registers the array output; stage 2 presents it.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_s1_valid <= 1'b0;
                    r_s1_data  <= '0;
                    r_valid    <= 1'b0;
                    r_dout     <= '0;
                end else begin
                    r_s1_valid <= en_b;
                    if (en_b) begin
                        r_s1_data <= w_rd_word;
                    end
                    r_valid <= r_s1_valid;
                    if (r_s1_valid) begin
                        r_dout <= r_s1_data;
                    end
                end
            end
`ifdef RAMSDP_BW_PARITY_EN
            logic [c_NL-1:0] r_s1_perr;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_s1_perr <= '0;
                    r_perr    <= '0;
                end else begin
                    r_s1_perr <= en_b ? w_rd_perr : '0;
                    r_perr    <= r_s1_valid ? r_s1_perr : '0;
                end
            end
`endif
        end
    endgenerate

    assign dout_b  = r_dout;
    assign valid_b = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_ramsdp_bw.sv
// ============================================================================
// Module   : tb_ramsdp_bw
// Brief    : Scoreboard bench for ramsdp_bw; two instances (RDLAT=1/RDW=0 and
//            RDLAT=2/RDW=1) share one stimulus stream, each with its own queue.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ramsdp_bw;

    localparam int DW = 32;
    localparam int AW = 6;
    localparam int BW = 8;
    localparam int NL = DW / BW;

    typedef struct {
        logic [DW-1:0] data;
        logic [NL-1:0] perr;
        int            due;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          en_a, we_a, en_b, pinj_a;
    logic [NL-1:0] wmask_a;
    logic [AW-1:0] addr_a, addr_b;
    logic [DW-1:0] din_a;
    logic [DW-1:0] dout1, dout2;
    logic          valid1, valid2;
    logic [NL-1:0] perr1, perr2;

    exp_t          q1[$];
    exp_t          q2[$];
    int            cyc    = 0;
    int            passed = 0;
    int            total  = 0;
    logic [DW-1:0] last1  = '0;
    logic [DW-1:0] last2  = '0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ramsdp_bw #(.DW(DW), .AW(AW), .BW(BW), .RDLAT(1), .RDW(0)) u_dut1 (
        .clk(clk), .rst(rst), .en_a(en_a), .we_a(we_a), .wmask_a(wmask_a),
        .addr_a(addr_a), .din_a(din_a),
`ifdef RAMSDP_BW_PARITY_EN
        .pinj_a(pinj_a), .perr_b(perr1),
`endif
        .en_b(en_b), .addr_b(addr_b), .dout_b(dout1), .valid_b(valid1)
    );

    ramsdp_bw #(.DW(DW), .AW(AW), .BW(BW), .RDLAT(2), .RDW(1)) u_dut2 (
        .clk(clk), .rst(rst), .en_a(en_a), .we_a(we_a), .wmask_a(wmask_a),
        .addr_a(addr_a), .din_a(din_a),
`ifdef RAMSDP_BW_PARITY_EN
        .pinj_a(pinj_a), .perr_b(perr2),
`endif
        .en_b(en_b), .addr_b(addr_b), .dout_b(dout2), .valid_b(valid2)
    );

`ifndef RAMSDP_BW_PARITY_EN
    assign perr1 = '0;
    assign perr2 = '0;
`endif

    task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Pops the queue of instance w whenever it presents valid_b.
    task automatic mon(input int w, input logic [DW-1:0] d, input logic v, input logic [NL-1:0] pe);
        exp_t e;
        int   n;
        n = (w == 1) ? q1.size() : q2.size();
        if (rst) begin
            chk($sformatf("dut%0d reset dout", w), d, '0);
            chk($sformatf("dut%0d reset valid", w), {31'b0, v}, '0);
            if (w == 1) last1 = '0; else last2 = '0;
            return;
        end
        if (n > 0) e = (w == 1) ? q1[0] : q2[0];
        if (v) begin
            if (n == 0) begin
                total++;
                $display("FAIL dut%0d unexpected valid: got dout %h expected no read", w, d);
            end else begin
                if (w == 1) void'(q1.pop_front()); else void'(q2.pop_front());
                chk($sformatf("dut%0d read data", w), d, e.data);
                chk($sformatf("dut%0d read latency", w), DW'(cyc), DW'(e.due));
                chk($sformatf("dut%0d perr", w), DW'(pe), DW'(e.perr));
            end
            if (w == 1) last1 = d; else last2 = d;
        end else begin
            chk($sformatf("dut%0d dout hold", w), d, (w == 1) ? last1 : last2);
            if (n > 0 && cyc > e.due) begin
                total++;
                $display("FAIL dut%0d missing valid: got none expected %h by cycle %0d", w, e.data, e.due);
                if (w == 1) void'(q1.pop_front()); else void'(q2.pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        mon(1, dout1, valid1, perr1);
        mon(2, dout2, valid2, perr2);
    end

    // One clock of stimulus; expectations are queued only for reads that count.
    task automatic op(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                      input logic [NL-1:0] m, input logic pj, input logic re,
                      input logic [AW-1:0] ra, input logic [DW-1:0] e1,
                      input logic [DW-1:0] e2, input logic [NL-1:0] ep);
        en_a = we; we_a = we; addr_a = wa; din_a = wd; wmask_a = m; pinj_a = pj;
        en_b = re; addr_b = ra;
        if (re && !rst) begin
            q1.push_back('{data: e1, perr: ep, due: cyc + 1});
            q2.push_back('{data: e2, perr: ep, due: cyc + 2});
        end
        @(posedge clk);
        #1;
        en_a = 1'b0; we_a = 1'b0; en_b = 1'b0; pinj_a = 1'b0;
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [NL-1:0] m);
        op(1'b1, a, d, m, 1'b0, 1'b0, '0, '0, '0, '0);
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] e);
        op(1'b0, '0, '0, '0, 1'b0, 1'b1, a, e, e, '0);
    endtask

    function automatic logic [DW-1:0] fillv(input int i);
        return 32'h5A00_0000 + DW'(i) * 32'h0001_0003;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        en_a = 1'b0; we_a = 1'b0; en_b = 1'b0; pinj_a = 1'b0;
        wmask_a = '0; addr_a = '0; addr_b = '0; din_a = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        wr(6'd5, 32'hDEAD_BEEF, 4'hF);
        rd(6'd5, 32'hDEAD_BEEF);
        wr(6'd5, 32'h1122_3344, 4'h5);
        rd(6'd5, 32'hDE22_BE44);

        wr(6'd9, 32'hAAAA_AAAA, 4'hF);
        op(1'b1, 6'd9, 32'h5555_5555, 4'h3, 1'b0, 1'b1, 6'd9,
           32'hAAAA_AAAA, 32'hAAAA_5555, 4'h0);
        rd(6'd9, 32'hAAAA_5555);
        wr(6'd9, 32'hFFFF_FFFF, 4'h0);
        rd(6'd9, 32'hAAAA_5555);

        for (int i = 0; i < 64; i++) wr(AW'(i), fillv(i), 4'hF);
        for (int i = 0; i < 64; i++) rd(AW'(i), fillv(i));
        repeat (4) @(posedge clk);
        #1;

        op(1'b1, 6'd20, 32'hCAFE_F00D, 4'hF, 1'b0, 1'b1, 6'd21,
           fillv(21), fillv(21), 4'h0);
        rd(6'd20, 32'hCAFE_F00D);
        repeat (3) @(posedge clk);
        #1;

        // In-flight read on the 2-cycle instance is killed by reset.
        en_b = 1'b1; addr_b = 6'd7;
        @(posedge clk);
        #1;
        rst = 1'b1; en_b = 1'b0;
        #1;
        chk("dut2 async reset valid", {31'b0, valid2}, '0);
        chk("dut2 async reset dout", dout2, '0);
        op(1'b1, 6'd7, 32'hBAD0_BAD0, 4'hF, 1'b0, 1'b1, 6'd7, '0, '0, '0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rd(6'd7, fillv(7));

`ifdef RAMSDP_BW_PARITY_EN
        op(1'b1, 6'd3, 32'h1234_5678, 4'h2, 1'b1, 1'b0, '0, '0, '0, '0);
        op(1'b0, '0, '0, '0, 1'b0, 1'b1, 6'd3, 32'h5A03_5609, 32'h5A03_5609, 4'h2);
        wr(6'd3, 32'h1234_5678, 4'hF);
        rd(6'd3, 32'h1234_5678);
`endif

        repeat (5) @(posedge clk);
        #1;
        chk("dut1 queue drained", DW'(q1.size()), '0);
        chk("dut2 queue drained", DW'(q2.size()), '0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
